// File: rtl/seg7_view.sv
// Debug display stage: samples the selected debug word and selection LEDs at a
// slow tick, with a debounced freeze key, onto six active-low 7-segment digits.
module seg7_view #(
    parameter int TICK_CYCLES = 5000000,
    parameter int DB_CYCLES   = 1000000,
    parameter bit LZB         = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] Vdata,
    input  logic [4:0]  SEL_LED,
    input  logic        HOLD_KEY,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        HOLD
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_H     = 7'h09;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Anything that is not exactly one-hot (including all-ones and zero) shows E.
    function automatic logic [6:0] sel_seg(input logic [4:0] sel);
        logic [6:0] seg;
        case (sel)
            5'b00001: seg = hex_seg(4'h0);
            5'b00010: seg = hex_seg(4'h1);
            5'b00100: seg = hex_seg(4'h2);
            5'b01000: seg = hex_seg(4'h3);
            5'b10000: seg = hex_seg(4'h4);
            default:  seg = SEG_E;
        endcase
        return seg;
    endfunction

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_s;
    logic          key_meta_q, key_sync_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_state_q, db_state_d;
    logic          press_q, press_d;
    logic          hold_q, hold_d;
    logic          capture_s;
    logic [15:0]   shadow_data_q, shadow_data_d;
    logic [4:0]    shadow_sel_q, shadow_sel_d;
    logic          shown_q, shown_d;
    logic          blank3_s, blank2_s, blank1_s;
    logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic [6:0]    hex0_d, hex1_d, hex2_d, hex3_d, hex4_d, hex5_d;

    wire unused_vdata_s = &{1'b0, Vdata[31:16]};

    // Tick generation, key debounce, hold toggle and capture next-state
    always_comb begin
        tick_s        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d    = tick_s ? '0 : tick_cnt_q + TW'(1);
        db_cnt_d      = db_cnt_q;
        db_state_d    = db_state_q;
        if (key_sync_q == db_state_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_state_d = key_sync_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DW'(1);
        end
        press_d       = db_state_q & ~db_state_d;
        hold_d        = press_q ? ~hold_q : hold_q;
        capture_s     = ~hold_q & (tick_s | (SEL_LED != shadow_sel_q));
        shadow_data_d = shadow_data_q;
        shadow_sel_d  = shadow_sel_q;
        shown_d       = shown_q;
        if (capture_s) begin
            shadow_data_d = Vdata[15:0];
            shadow_sel_d  = SEL_LED;
            shown_d       = 1'b1;
        end else begin
            shown_d       = shown_q;
        end
    end

    // Decode of the shadowed word; blank until the first capture after reset
    always_comb begin
        blank3_s = LZB && (shadow_data_q[15:12] == 4'h0);
        blank2_s = blank3_s && (shadow_data_q[11:8] == 4'h0);
        blank1_s = blank2_s && (shadow_data_q[7:4] == 4'h0);
        hex0_d   = SEG_BLANK;
        hex1_d   = SEG_BLANK;
        hex2_d   = SEG_BLANK;
        hex3_d   = SEG_BLANK;
        hex4_d   = SEG_BLANK;
        if (shown_q) begin
            hex0_d = hex_seg(shadow_data_q[3:0]);
            hex1_d = blank1_s ? SEG_BLANK : hex_seg(shadow_data_q[7:4]);
            hex2_d = blank2_s ? SEG_BLANK : hex_seg(shadow_data_q[11:8]);
            hex3_d = blank3_s ? SEG_BLANK : hex_seg(shadow_data_q[15:12]);
            hex4_d = sel_seg(shadow_sel_q);
        end else begin
            hex4_d = SEG_BLANK;
        end
        hex5_d = hold_q ? SEG_H : SEG_BLANK;
    end

    // The key synchronizer and debounced level idle high (released)
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            tick_cnt_q    <= '0;
            key_meta_q    <= 1'b1;
            key_sync_q    <= 1'b1;
            db_cnt_q      <= '0;
            db_state_q    <= 1'b1;
            press_q       <= 1'b0;
            hold_q        <= 1'b0;
            shadow_data_q <= 16'h0000;
            shadow_sel_q  <= 5'b00000;
            shown_q       <= 1'b0;
            hex0_q        <= SEG_BLANK;
            hex1_q        <= SEG_BLANK;
            hex2_q        <= SEG_BLANK;
            hex3_q        <= SEG_BLANK;
            hex4_q        <= SEG_BLANK;
            hex5_q        <= SEG_BLANK;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            key_meta_q    <= HOLD_KEY;
            key_sync_q    <= key_meta_q;
            db_cnt_q      <= db_cnt_d;
            db_state_q    <= db_state_d;
            press_q       <= press_d;
            hold_q        <= hold_d;
            shadow_data_q <= shadow_data_d;
            shadow_sel_q  <= shadow_sel_d;
            shown_q       <= shown_d;
            hex0_q        <= hex0_d;
            hex1_q        <= hex1_d;
            hex2_q        <= hex2_d;
            hex3_q        <= hex3_d;
            hex4_q        <= hex4_d;
            hex5_q        <= hex5_d;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign HEX4 = hex4_q;
    assign HEX5 = hex5_q;
    assign HOLD = hold_q;

endmodule

// File: tb/tb_seg7_view.sv
// Randomized scoreboard bench for seg7_view: an event-level reference model
// predicts every output each cycle for a plain and a leading-zero-blanking build.
module tb_seg7_view;
    localparam int TICK = 10;
    localparam int DB   = 4;
    localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        CLK      = 1'b0;
    logic        RST_X    = 1'b1;
    logic [31:0] Vdata    = 32'h0000_0000;
    logic [4:0]  SEL_LED  = 5'b00001;
    logic        HOLD_KEY = 1'b1;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        HOLD;
    logic [6:0]  LHEX0, LHEX1, LHEX2, LHEX3, LHEX4, LHEX5;
    logic        LHOLD;

    typedef struct packed {
        logic [42:0] main;
        logic [42:0] lzb;
    } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    seg7_view #(.TICK_CYCLES(TICK), .DB_CYCLES(DB), .LZB(1'b0)) dut (
        .CLK(CLK), .RST_X(RST_X), .Vdata(Vdata), .SEL_LED(SEL_LED), .HOLD_KEY(HOLD_KEY),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .HOLD(HOLD));

    seg7_view #(.TICK_CYCLES(TICK), .DB_CYCLES(DB), .LZB(1'b1)) dut_lzb (
        .CLK(CLK), .RST_X(RST_X), .Vdata(Vdata), .SEL_LED(SEL_LED), .HOLD_KEY(HOLD_KEY),
        .HEX0(LHEX0), .HEX1(LHEX1), .HEX2(LHEX2), .HEX3(LHEX3), .HEX4(LHEX4), .HEX5(LHEX5),
        .HOLD(LHOLD));

    always #5 CLK = ~CLK;

    // What the display should show for a given shown word/selection and hold state.
    function automatic logic [42:0] expect_out(input logic [15:0] d, input logic [4:0] s,
                                                input bit shown, input bit hold_pre,
                                                input bit hold_post, input bit lzb);
        logic [6:0] h [6];
        int ndig;
        ndig = 1;
        for (int i = 1; i < 4; i++) if ((d >> (4 * i)) != 16'h0000) ndig = i + 1;
        for (int i = 0; i < 4; i++) begin
            if (!shown || (lzb && i >= ndig)) h[i] = 7'h7F;
            else h[i] = SEG_TBL[int'((d >> (4 * i)) & 16'h000F)];
        end
        h[4] = 7'h7F;
        if (shown) begin
            h[4] = 7'h06;
            if ($countones(s) == 1)
                for (int k = 0; k < 5; k++) if (s[k]) h[4] = SEG_TBL[k];
        end
        h[5] = hold_pre ? 7'h09 : 7'h7F;
        return {hold_post, h[5], h[4], h[3], h[2], h[1], h[0]};
    endfunction

    // Reference model: edge-indexed history of the raw key, tick by modular arithmetic.
    initial begin : model
        bit         raw_hist[$];
        int         e;
        bit         m_deb, m_fell, m_hold, m_shown, tick, cap, accept, new_hold, new_fell, syn;
        logic [15:0] m_data;
        logic [4:0]  m_sel;
        exp_t        x;
        e = 0; m_deb = 1'b1; m_fell = 1'b0; m_hold = 1'b0; m_shown = 1'b0;
        m_data = 16'h0000; m_sel = 5'b00000;
        forever begin
            @(posedge CLK);
            if (!RST_X) begin
                raw_hist.delete();
                e = 0; m_deb = 1'b1; m_fell = 1'b0; m_hold = 1'b0; m_shown = 1'b0;
                m_data = 16'h0000; m_sel = 5'b00000;
                x.main = expect_out(16'h0000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
                x.lzb  = x.main;
            end else begin
                tick = ((e % TICK) == TICK - 1);
                cap  = !m_hold && (tick || (SEL_LED != m_sel));
                // the debouncer sees the key two edges late; accept after DB differing samples
                accept = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    syn = (e - j - 2 >= 0) ? raw_hist[e - j - 2] : 1'b1;
                    if (syn == m_deb) accept = 1'b0;
                end
                new_hold = m_fell ? !m_hold : m_hold;
                new_fell = accept && m_deb;
                x.main = expect_out(m_data, m_sel, m_shown, m_hold, new_hold, 1'b0);
                x.lzb  = expect_out(m_data, m_sel, m_shown, m_hold, new_hold, 1'b1);
                if (accept) m_deb = !m_deb;
                if (cap) begin
                    m_data  = Vdata[15:0];
                    m_sel   = SEL_LED;
                    m_shown = 1'b1;
                end
                m_hold = new_hold;
                m_fell = new_fell;
                raw_hist.push_back(HOLD_KEY);
                e++;
            end
            exp_q.push_back(x);
        end
    end

    // Monitor: pops one prediction per cycle and compares on the falling edge.
    initial begin : monitor
        exp_t        x;
        logic [42:0] got_main, got_lzb;
        forever begin
            @(negedge CLK);
            cyc_no++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL queue_empty cyc=%0d got=empty required=one prediction", cyc_no);
            end else begin
                x = exp_q.pop_front();
                got_main = {HOLD, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
                got_lzb  = {LHOLD, LHEX5, LHEX4, LHEX3, LHEX2, LHEX1, LHEX0};
                if (got_main !== x.main) begin
                    n_bad++;
                    $display("FAIL main cyc=%0d got=%h required=%h", cyc_no, got_main, x.main);
                end
                n_cmp++;
                if (got_lzb !== x.lzb) begin
                    n_bad++;
                    $display("FAIL lzb cyc=%0d got=%h required=%h", cyc_no, got_lzb, x.lzb);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(input int lo);
        HOLD_KEY = 1'b0;
        cyc(lo);
        HOLD_KEY = 1'b1;
        cyc(DB + 4);
    endtask

    function automatic logic [4:0] rand_sel();
        int pick;
        pick = $urandom_range(0, 7);
        if (pick < 5) return 5'(1 << pick);
        else if (pick == 5) return 5'b11111;
        else if (pick == 6) return 5'b00000;
        else return 5'($urandom);
    endfunction

    initial begin : stim
        int key_left;
        int pick;
        #1 RST_X = 1'b0;
        Vdata = 32'h0000_1234;
        SEL_LED = 5'b00001;
        cyc(3);
        RST_X = 1'b1;
        cyc(6);
        Vdata = 32'h0000_ABCD; SEL_LED = 5'b00100;
        cyc(4);
        Vdata = 32'hDEAD_BEEF; SEL_LED = 5'b11111;
        cyc(3);
        Vdata = 32'h0000_0050; SEL_LED = 5'b00010;
        cyc(TICK + 2);
        Vdata = 32'h0000_0000;
        cyc(TICK + 2);
        HOLD_KEY = 1'b0;
        cyc(3);
        HOLD_KEY = 1'b1;
        cyc(10);
        press(8);
        for (int i = 0; i < 35; i++) begin
            Vdata = $urandom;
            if (i % 7 == 0) SEL_LED = rand_sel();
            cyc(1);
        end
        press(8);
        cyc(2 * TICK);
        press(6);
        HOLD_KEY = 1'b0;
        cyc(2);
        @(negedge CLK);
        #1 RST_X = 1'b0;
        cyc(2);
        HOLD_KEY = 1'b1;
        RST_X = 1'b1;
        cyc(5);
        key_left = 5;
        for (int i = 0; i < 2500; i++) begin
            pick = $urandom_range(0, 8);
            if (pick == 0) Vdata = $urandom;
            else if (pick == 1) Vdata = $urandom & 32'h0000_00FF;
            else if (pick == 2) Vdata = $urandom & 32'h0000_000F;
            else if (pick == 3) Vdata = 32'h0000_0000;
            if ($urandom_range(0, 7) == 0) SEL_LED = rand_sel();
            key_left--;
            if (key_left <= 0) begin
                HOLD_KEY = ~HOLD_KEY;
                key_left = $urandom_range(1, 12);
            end
            cyc(1);
        end
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
